pll_reset_sequencer: RTL and testbench
======================================

// Module: pll_reset_sequencer
// PURPOSE
// Consumes the lock indication of the system PLL (50 MHz ref -> 30 / 1.843 / 51.18 MHz) and
// produces a clean, sequenced active-low system reset for logic in the PLL output domains.
// Pulses the PLL reset at power-up and on lock timeout, qualifies lock for a stable interval,
// and re-asserts system reset immediately on loss of lock. Runs on the PLL reference clock,
// so it keeps running while the PLL is unlocked.
// PARAMETERS
// SYNC_STAGES     2      synchronizer depth for the asynchronous locked input (>=2)
// PLL_RST_CYCLES  16     cycles pll_rst is held high per PLL reset pulse (>=1)
// LOCK_TIMEOUT    100000 cycles allowed in WAIT_LOCK before the PLL is reset again (>=1)
// LOCK_STABLE     1024   consecutive synchronized-locked cycles required before release (>=1)
// PORTS
// clk          in   1  PLL reference clock (50 MHz)
// rst_n        in   1  asynchronous active-low reset
// pll_locked   in   1  PLL locked output; asynchronous to clk
// pll_rst      out  1  active-high reset to the PLL rst input
// sys_rst_n    out  1  active-low system reset; deasserts only in RUN
// ready        out  1  high exactly while in RUN
// retry_cnt    out  8  number of lock timeouts since rst_n; saturates at 255
// BEHAVIOUR
// - Reset (rst_n=0, async): state=PLL_RST, counter=0, sync chain=0, pll_rst=1, sys_rst_n=0,
//   ready=0, retry_cnt=0. All outputs registered; no combinational path input->output.
// - locked_s = pll_locked after SYNC_STAGES flops (latency SYNC_STAGES cycles).
// - Single counter (width from max parameter) cleared on every state transition.
// - PLL_RST: pll_rst=1, sys_rst_n=0. After PLL_RST_CYCLES cycles -> WAIT_LOCK.
// - WAIT_LOCK: pll_rst=0, sys_rst_n=0. locked_s=1 -> STABLE. Else counter reaching
//   LOCK_TIMEOUT -> PLL_RST and retry_cnt+1 (saturating). locked_s before timeout wins.
// - STABLE: pll_rst=0, sys_rst_n=0. locked_s=0 on any cycle -> WAIT_LOCK (counter restarts,
//   timeout window restarts). After LOCK_STABLE consecutive locked_s=1 cycles -> RUN.
// - RUN: sys_rst_n=1, ready=1. locked_s=0 -> WAIT_LOCK; sys_rst_n and ready go low on the
//   same edge that leaves RUN (lock loss to reset assertion = SYNC_STAGES+1 cycles).
// - Outputs are decoded from the next-state so they change on the edge entering a state:
//   pll_rst rises on the edge entering PLL_RST, sys_rst_n rises on the edge entering RUN.
// - Glitches on pll_locked shorter than one clk period may be missed or seen; either is
//   legal, but one synchronized low cycle in STABLE or RUN always restarts qualification.
// - rst_n asserted mid-sequence (any state) returns to the reset values immediately,
//   including retry_cnt=0; sequence restarts with a full PLL_RST pulse on release.
// - Illegal state encodings recover to PLL_RST on the next clk.
// TESTING (bench uses PLL_RST_CYCLES=4, LOCK_TIMEOUT=20, LOCK_STABLE=8, SYNC_STAGES=2)
// 1 Release rst_n, raise pll_locked at cycle 6 and hold -> pll_rst high cycles 0-3,
//   sys_rst_n=1 and ready=1 from cycle 6+2+8+1=17 (+/-0), retry_cnt=0.
// 2 Keep pll_locked=0 -> pll_rst re-pulses for 4 cycles every 4+20 cycles; retry_cnt
//   increments 1,2,3; force 300 timeouts -> retry_cnt holds 255.
// 3 In STABLE drop pll_locked for 1 cycle after 5 locked cycles -> no release; full 8-cycle
//   qualification restarts once locked_s returns; sys_rst_n stays 0 throughout.
// 4 In RUN drop pll_locked -> sys_rst_n=0, ready=0 exactly 3 cycles later; relock ->
//   release after 8 stable cycles without a new pll_rst pulse.
// 5 Assert rst_n mid-STABLE with retry_cnt=2 -> all outputs at reset values in same
//   timestep; on release, pll_rst pulse of 4 cycles, retry_cnt=0.
// 6 Random pll_locked toggling for 10k cycles -> assertion: sys_rst_n=1 implies locked_s
//   was 1 for the previous 8 cycles; pll_rst and sys_rst_n=1 never high together.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
// pll_reset_sequencer
// Sequences the PLL reset and the downstream active-low system reset from the
// PLL lock indication. Runs on the PLL reference clock, so it keeps running
// while the PLL is unlocked. Every output is a flop driven from the next
// state, so each output changes on the same edge that enters the matching state.
module pll_reset_sequencer #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 100000,
    parameter int LOCK_STABLE    = 1024
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst_n,
    output logic       ready,
    output logic [7:0] retry_cnt
);

    // One shared counter sized for the longest interval it must measure.
    localparam int MAX_A   = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
    localparam int MAX_CNT = (MAX_A > LOCK_STABLE) ? MAX_A : LOCK_STABLE;
    localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

    // Terminal counts: the counter starts at 0 on state entry, so the last
    // cycle of an N-cycle interval is count N-1.
    localparam logic [CNT_W-1:0] PR_LAST  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE - 1);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    state_t                 state;
    state_t                 state_next;
    logic [CNT_W-1:0]       count;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    logic                   timeout;

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Bring the asynchronous lock indication into the clk domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    // Next-state decision; a lock seen on the timeout cycle takes priority.
    always_comb begin
        state_next = state;
        timeout    = 1'b0;
        case (state)
            ST_PLL_RST: begin
                if (count == PR_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABLE;
                end else if (count == TO_LAST) begin
                    state_next = ST_PLL_RST;
                    timeout    = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (count == STB_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase
    end

    // State, interval counter, retry count and outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PLL_RST;
            count     <= '0;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            ready     <= 1'b0;
            retry_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if ((state_next != state) || (state == ST_RUN)) begin
                count <= '0;
            end else begin
                count <= count + CNT_W'(1);
            end
            pll_rst   <= (state_next == ST_PLL_RST);
            sys_rst_n <= (state_next == ST_RUN);
            ready     <= (state_next == ST_RUN);
            if (timeout && (retry_cnt != 8'hFF)) begin
                retry_cnt <= retry_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
`timescale 1ns/1ps
// tb_pll_reset_sequencer
// Drives pll_locked on the falling clock edge, keeps a timestamp-based model of
// the reset sequence, and compares every output on each falling edge. Directed
// scenarios add literal expectations, then a long random run exercises the model.
module tb_pll_reset_sequencer;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int LOCK_STABLE    = 8;
    localparam int HALF_PERIOD    = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       ready;
    logic [7:0] retry_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    pll_reset_sequencer #(
        .SYNC_STAGES   (SYNC_STAGES),
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .LOCK_STABLE   (LOCK_STABLE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .pll_locked(pll_locked),
        .pll_rst   (pll_rst),
        .sys_rst_n (sys_rst_n),
        .ready     (ready),
        .retry_cnt (retry_cnt)
    );

    always #HALF_PERIOD clk = ~clk;

    // Reference model: phase plus the clock count at which the phase was entered.
    typedef enum int {M_PR, M_WL, M_ST, M_RUN} mode_t;
    mode_t m_mode;
    int    m_enter;
    int    cyc;
    int    m_retry;
    int    seen_run;
    logic  hist[$];

    task automatic modelReset();
        m_mode   = M_PR;
        m_enter  = 0;
        cyc      = 0;
        m_retry  = 0;
        seen_run = 0;
        hist.delete();
        for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
    endtask

    task automatic modelEnter(input mode_t m);
        m_mode  = m;
        m_enter = cyc;
    endtask

    task automatic modelStep();
        logic seen;
        cyc++;
        seen = hist.pop_front();
        hist.push_back(pll_locked);
        seen_run = seen ? seen_run + 1 : 0;
        case (m_mode)
            M_PR:  if (cyc - m_enter == PLL_RST_CYCLES) modelEnter(M_WL);
            M_WL: begin
                if (seen) modelEnter(M_ST);
                else if (cyc - m_enter == LOCK_TIMEOUT) begin
                    modelEnter(M_PR);
                    if (m_retry < 255) m_retry++;
                end
            end
            M_ST: begin
                if (!seen) modelEnter(M_WL);
                else if (cyc - m_enter == LOCK_STABLE) modelEnter(M_RUN);
            end
            default: if (!seen) modelEnter(M_WL);
        endcase
    endtask

    // Advance the model on each active edge, or clear it on reset assertion.
    initial begin
        modelReset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) modelReset();
            else modelStep();
        end
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_cmp++;
        if (actual !== expected) begin
            n_bad++;
            $display("[TB] FAIL %s at t=%0t cyc=%0d: got %0d, expected %0d", name, $time, cyc, actual, expected);
        end
    endtask

    // Per-cycle comparison of all outputs against the model, plus invariants.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                checkOutput("pll_rst", int'(pll_rst), int'(m_mode == M_PR));
                checkOutput("sys_rst_n", int'(sys_rst_n), int'(m_mode == M_RUN));
                checkOutput("ready", int'(ready), int'(m_mode == M_RUN));
                checkOutput("retry_cnt", int'(retry_cnt), m_retry);
                checkOutput("rst_exclusive", int'(pll_rst && sys_rst_n), 0);
                if (sys_rst_n) checkOutput("lock_history", int'(seen_run >= LOCK_STABLE), 1);
            end
        end
    end

    // Abort guard so the run always ends on its own.
    initial begin
        #1000000;
        n_bad++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "[TB] watchdog expired");
    end

    // One cycle: wait for the falling edge, then drive the lock level.
    task automatic applyStimulus(input logic lk);
        @(negedge clk);
        #1 pll_locked = lk;
    endtask

    // Hold reset, check reset values, release mid-cycle (that cycle is cycle 0).
    task automatic doReset(input logic lk);
        @(negedge clk);
        #1 rst_n = 1'b0;
        pll_locked = lk;
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst_pll_rst", int'(pll_rst), 1);
        checkOutput("rst_sys_rst_n", int'(sys_rst_n), 0);
        checkOutput("rst_ready", int'(ready), 0);
        checkOutput("rst_retry", int'(retry_cnt), 0);
        rst_n = 1'b1;
    endtask

    int pr_hi;
    int rel_at;
    int flag;
    int n;
    int run_len;
    int run_cycles;
    logic lvl;

    initial begin
        $display("[TB] start");

        // Scenario 1: lock at cycle 6 -> release at cycle 17.
        doReset(1'b0);
        pr_hi  = int'(pll_rst);
        rel_at = -1;
        for (int k = 1; k <= 30; k++) begin
            applyStimulus(k >= 6);
            if (pll_rst) pr_hi++;
            if (sys_rst_n && rel_at < 0) rel_at = k;
        end
        checkOutput("t1_pll_rst_cycles", pr_hi, 4);
        checkOutput("t1_release_cycle", rel_at, 17);
        checkOutput("t1_ready", int'(ready), 1);
        checkOutput("t1_retry", int'(retry_cnt), 0);

        // Scenario 2: no lock -> re-pulse every 24 cycles, then saturation.
        doReset(1'b0);
        for (int k = 1; k <= 72; k++) begin
            applyStimulus(1'b0);
            if (k % 24 == 0) begin
                checkOutput("t2_pll_rst_rise", int'(pll_rst), 1);
                checkOutput("t2_retry", int'(retry_cnt), k / 24);
            end
            if (k % 24 == 23) checkOutput("t2_pll_rst_before", int'(pll_rst), 0);
            if (k % 24 == 4) checkOutput("t2_pll_rst_end", int'(pll_rst), 0);
        end
        repeat (300 * 24) applyStimulus(1'b0);
        checkOutput("t2_retry_sat", int'(retry_cnt), 255);

        // Scenario 3: one-cycle drop in STABLE restarts qualification.
        doReset(1'b0);
        flag = 0;
        for (int k = 1; k <= 26; k++) begin
            applyStimulus((k >= 6) && (k != 13));
            if (k < 25 && sys_rst_n) flag = 1;
            if (k == 25) checkOutput("t3_release", int'(sys_rst_n), 1);
        end
        checkOutput("t3_no_early_release", flag, 0);

        // Scenario 4: loss of lock in RUN, then relock without a PLL pulse.
        flag = 0;
        for (int k = 27; k <= 52; k++) begin
            applyStimulus(!((k >= 30) && (k < 40)));
            if (pll_rst) flag = 1;
            if (k == 32) checkOutput("t4_still_run", int'(sys_rst_n), 1);
            if (k == 33) begin
                checkOutput("t4_sys_rst_n_low", int'(sys_rst_n), 0);
                checkOutput("t4_ready_low", int'(ready), 0);
            end
            if (k == 50) checkOutput("t4_not_yet", int'(sys_rst_n), 0);
            if (k == 51) checkOutput("t4_rerelease", int'(sys_rst_n), 1);
        end
        checkOutput("t4_no_pll_pulse", flag, 0);

        // Scenario 5: reset mid-STABLE with two retries recorded.
        doReset(1'b0);
        for (int k = 1; k <= 57; k++) applyStimulus(k >= 50);
        checkOutput("t5_retry_before", int'(retry_cnt), 2);
        checkOutput("t5_in_stable", int'(pll_rst | sys_rst_n), 0);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("t5_async_pll_rst", int'(pll_rst), 1);
        checkOutput("t5_async_sys_rst_n", int'(sys_rst_n), 0);
        checkOutput("t5_async_ready", int'(ready), 0);
        checkOutput("t5_async_retry", int'(retry_cnt), 0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        pr_hi = int'(pll_rst);
        for (int k = 1; k <= 10; k++) begin
            applyStimulus(1'b1);
            if (pll_rst) pr_hi++;
            if (k == 3) checkOutput("t5_pulse_last", int'(pll_rst), 1);
            if (k == 4) checkOutput("t5_pulse_end", int'(pll_rst), 0);
        end
        checkOutput("t5_pulse_len", pr_hi, 4);
        checkOutput("t5_retry_after", int'(retry_cnt), 0);

        // Scenario 6: random lock toggling with occasional long outages.
        doReset(1'b0);
        n = 0;
        run_cycles = 0;
        lvl = 1'b0;
        while (n < 10000) begin
            lvl = ~lvl;
            if (lvl) run_len = $urandom_range(1, 40);
            else if ($urandom_range(0, 9) == 0) run_len = $urandom_range(25, 60);
            else run_len = $urandom_range(1, 8);
            for (int j = 0; j < run_len; j++) begin
                applyStimulus(lvl);
                if (sys_rst_n) run_cycles++;
                n++;
            end
        end
        $display("[TB] random phase: %0d cycles, %0d cycles released", n, run_cycles);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
